fetch_ctrl: RTL and testbench

- Control and realignment partner of the instruction-fetch stage; sits between fetch and decode.
- Drives fetch's stall, imm_pc and next_imm_pc inputs.
- Realigns fetch's pc output with the 1-cycle-latency BRAM instruction output.
- Squashes wrong-path slots after a redirect, holds the instruction across stalls, and presents a valid/ready fetch packet to decode.

---
 rtl/fetch_ctrl_pkg.sv | 11 +
 rtl/fetch_ctrl_if.sv | 35 +++
 rtl/fetch_ctrl_skid.sv | 40 ++++
 rtl/fetch_ctrl.sv | 86 ++++++++
 tb/tb_fetch_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-path helpers: byte/word address conversion.
// Used by fetch_ctrl and its skid sub-module.
package fetch_ctrl_pkg;

    localparam int INSTR_ALIGN_BITS = 2;

    function automatic logic [63:0] byte_to_word(input logic [63:0] addr);
        return addr >> INSTR_ALIGN_BITS;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch/decode/redirect signal bundle around fetch_ctrl.
// slave = fetch_ctrl side, master = environment (fetch, execute, decode).
interface fetch_ctrl_if #(
    parameter int BUS_WIDTH     = 64,
    parameter int INSTR_MEM_LEN = 15,
    parameter int INSTR_WIDTH   = 32,
    parameter int CNT_WIDTH     = 32
);
    logic [BUS_WIDTH-1:0]     f_pc;
    logic [INSTR_WIDTH-1:0]   f_instr;
    logic                     f_stall;
    logic                     f_imm_pc;
    logic [INSTR_MEM_LEN-1:0] f_next_imm_pc;
    logic                     redirect_valid;
    logic [BUS_WIDTH-1:0]     redirect_target;
    logic                     d_valid;
    logic                     d_ready;
    logic [BUS_WIDTH-1:0]     d_pc;
    logic [INSTR_WIDTH-1:0]   d_instr;
    logic                     redirect_err;
    logic [CNT_WIDTH-1:0]     n_fetched;
    logic [CNT_WIDTH-1:0]     n_squashed;

    modport slave (
        input  f_pc, f_instr, redirect_valid, redirect_target, d_ready,
        output f_stall, f_imm_pc, f_next_imm_pc, d_valid, d_pc, d_instr,
               redirect_err, n_fetched, n_squashed
    );

    modport master (
        output f_pc, f_instr, redirect_valid, redirect_target, d_ready,
        input  f_stall, f_imm_pc, f_next_imm_pc, d_valid, d_pc, d_instr,
               redirect_err, n_fetched, n_squashed
    );
endinterface

// File: rtl/fetch_ctrl_skid.sv
// Holds the BRAM word across a stall, since the BRAM keeps reading ahead of pc.
// Latency 0 (mux); captures on the first stalled edge, released when the stall ends.
module fetch_ctrl_skid
    import fetch_ctrl_pkg::*;
#(
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic [INSTR_WIDTH-1:0] f_instr_i,
    output logic [INSTR_WIDTH-1:0] d_instr_o
);
    logic                   hold_valid_q, hold_valid_d;
    logic [INSTR_WIDTH-1:0] hold_instr_q, hold_instr_d;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        if (flush_i || !stall_i) begin
            hold_valid_d = 1'b0;
        end else if (!hold_valid_q) begin
            hold_valid_d = 1'b1;
            hold_instr_d = f_instr_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_instr_q <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    assign d_instr_o = hold_valid_q ? hold_instr_q : f_instr_i;
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch control: realigns pc with 1-cycle BRAM data, squashes after redirects.
// Latency 1 cycle fetch->decode; d_ready low stalls fetch, a redirect overrides the stall.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int BUS_WIDTH     = 64,
    parameter int INSTR_MEM_LEN = 15,
    parameter int INSTR_WIDTH   = 32,
    parameter int CNT_WIDTH     = 32
) (
    input logic          clk,
    input logic          rst,
    fetch_ctrl_if.slave  bus
);
    logic [63:0]          tgt_word;
    logic                 tgt_legal;
    logic                 acc_redirect;
    logic                 stall;

    logic [BUS_WIDTH-1:0] pc_q, pc_d;
    logic                 vld_q, vld_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] nf_q, nf_d;
    logic [CNT_WIDTH-1:0] ns_q, ns_d;

    // Legal: word aligned and inside the instruction memory.
    assign tgt_word     = byte_to_word(64'(bus.redirect_target));
    assign tgt_legal    = (bus.redirect_target[INSTR_ALIGN_BITS-1:0] == '0) &&
                          (tgt_word[63:INSTR_MEM_LEN] == '0);
    assign acc_redirect = ~rst & bus.redirect_valid & tgt_legal;
    assign stall        = ~rst & vld_q & ~bus.d_ready & ~acc_redirect;

    always_comb begin
        pc_d  = pc_q;
        vld_d = vld_q;
        err_d = err_q;
        nf_d  = nf_q;
        ns_d  = ns_q;
        if (!stall) begin
            pc_d  = bus.f_pc;
            vld_d = ~acc_redirect;
        end
        if (bus.redirect_valid && !tgt_legal)
            err_d = 1'b1;
        if (vld_q && bus.d_ready && !acc_redirect)
            nf_d = nf_q + CNT_WIDTH'(1);
        if (acc_redirect)
            ns_d = ns_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= '0;
            vld_q <= 1'b0;
            err_q <= 1'b0;
            nf_q  <= '0;
            ns_q  <= '0;
        end else begin
            pc_q  <= pc_d;
            vld_q <= vld_d;
            err_q <= err_d;
            nf_q  <= nf_d;
            ns_q  <= ns_d;
        end
    end

    fetch_ctrl_skid #(
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .stall_i   (stall),
        .flush_i   (acc_redirect),
        .f_instr_i (bus.f_instr),
        .d_instr_o (bus.d_instr)
    );

    assign bus.f_stall       = stall;
    assign bus.f_imm_pc      = acc_redirect;
    assign bus.f_next_imm_pc = tgt_word[INSTR_MEM_LEN-1:0];
    assign bus.d_valid       = vld_q;
    assign bus.d_pc          = pc_q;
    assign bus.redirect_err  = err_q;
    assign bus.n_fetched     = nf_q;
    assign bus.n_squashed    = ns_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboarded bench for fetch_ctrl with a fetch-stage + BRAM model around it.
// Expected packet stream comes from an architectural pc model driven by redirect events.
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_ctrl_if #(.BUS_WIDTH(64), .INSTR_MEM_LEN(15), .INSTR_WIDTH(32), .CNT_WIDTH(32)) bus ();

    fetch_ctrl #(.BUS_WIDTH(64), .INSTR_MEM_LEN(15), .INSTR_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memw(input logic [63:0] pc);
        return 32'(pc[16:2]) + 32'h100;
    endfunction

    // Fetch stage and BRAM: word read at each edge from the pre-edge pc.
    logic [63:0] cur_pc;
    logic [31:0] bram_q;
    always @(posedge clk or posedge rst) begin
        if (rst)               cur_pc <= 64'd0;
        else if (bus.f_imm_pc) cur_pc <= {47'd0, bus.f_next_imm_pc, 2'b00};
        else if (!bus.f_stall) cur_pc <= cur_pc + 64'd4;
    end
    always @(posedge clk) bram_q <= memw(cur_pc);
    assign bus.f_pc    = cur_pc;
    assign bus.f_instr = bram_q;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    typedef struct { int cyc; bit legal; logic [63:0] tgt; } ev_t;
    ev_t evq[$];

    function automatic bit is_legal(input logic [63:0] t);
        return (t % 4 == 0) && (t < 64'(1 << 17));
    endfunction

    task automatic drive(input bit ready, input bit rv, input logic [63:0] tgt);
        @(posedge clk);
        #1;
        bus.d_ready         = ready;
        bus.redirect_valid  = rv;
        bus.redirect_target = tgt;
        if (rv && !rst) evq.push_back('{cyc, is_legal(tgt), tgt});
    endtask

    // Reference model: m_pc is the pc of the next packet decode should see.
    bit          m_v;
    logic [63:0] m_pc;
    logic [31:0] m_nf, m_ns;
    bit          m_err;
    bit          acc, illg;
    logic [63:0] ev_tgt;
    ev_t         ev;

    always @(negedge clk) begin
        if (rst) begin
            m_v = 0; m_pc = 0; m_nf = 0; m_ns = 0; m_err = 0;
            evq.delete();
        end else begin
            acc = 0; illg = 0; ev_tgt = 0;
            if (evq.size() != 0 && evq[0].cyc == cyc) begin
                ev = evq.pop_front();
                acc = ev.legal; illg = !ev.legal; ev_tgt = ev.tgt;
            end
            chk("d_valid", 64'(bus.d_valid), 64'(m_v));
            if (m_v) begin
                chk("d_pc", bus.d_pc, m_pc);
                chk("d_instr", 64'(bus.d_instr), 64'(memw(m_pc)));
            end
            chk("n_fetched", 64'(bus.n_fetched), 64'(m_nf));
            chk("n_squashed", 64'(bus.n_squashed), 64'(m_ns));
            chk("redirect_err", 64'(bus.redirect_err), 64'(m_err));
            if (acc) begin
                m_ns = m_ns + 1; m_v = 0; m_pc = ev_tgt;
            end else if (!m_v) begin
                m_v = 1;
            end else if (bus.d_ready) begin
                m_nf = m_nf + 1; m_pc = m_pc + 4;
            end
            if (illg) m_err = 1;
        end
    end

    logic [63:0] rt;
    initial begin
        bus.d_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = 64'd0;

        // Reset: a legal redirect must not reach fetch while rst is high.
        drive(1, 1, 64'h40);
        #1;
        chk("rst_imm_pc", 64'(bus.f_imm_pc), 64'd0);
        chk("rst_stall", 64'(bus.f_stall), 64'd0);
        chk("rst_valid", 64'(bus.d_valid), 64'd0);
        chk("rst_nf", 64'(bus.n_fetched), 64'd0);
        drive(1, 0, 0);
        drive(1, 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Stream, then stall three cycles on pc 8.
        drive(1, 0, 0);
        drive(1, 0, 0);
        drive(0, 0, 0);
        #1 chk("stall_high", 64'(bus.f_stall), 64'd1);
        drive(0, 0, 0);
        drive(0, 0, 0);
        repeat (3) drive(1, 0, 0);

        // Redirect while streaming.
        drive(1, 1, 64'h40);
        #1 chk("redir_imm_pc", 64'(bus.f_imm_pc), 64'd1);
        repeat (4) drive(1, 0, 0);

        // Redirect during a stall overrides it.
        drive(0, 0, 0);
        drive(0, 0, 0);
        drive(0, 1, 64'h80);
        #1 chk("redir_stall_low", 64'(bus.f_stall), 64'd0);
        repeat (4) drive(1, 0, 0);

        // Illegal redirects are dropped.
        drive(1, 1, 64'h42);
        #1 chk("misalign_imm_pc", 64'(bus.f_imm_pc), 64'd0);
        drive(1, 0, 0);
        drive(1, 0, 0);
        drive(1, 1, 64'd1 << 17);
        #1 chk("range_imm_pc", 64'(bus.f_imm_pc), 64'd0);
        repeat (3) drive(1, 0, 0);
        chk("err_sticky", 64'(bus.redirect_err), 64'd1);

        // Random traffic with mixed legal/illegal redirects.
        for (int i = 0; i < 1500; i++) begin
            rt = 64'($urandom_range(0, 32767)) * 4;
            case ($urandom_range(0, 3))
                2:       rt = rt + 64'($urandom_range(1, 3));
                3:       rt = rt + (64'($urandom_range(1, 1000)) << 17);
                default: ;
            endcase
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, rt);
        end

        // Asynchronous reset in the middle of a stall.
        repeat (3) drive(1, 0, 0);
        drive(0, 0, 0);
        drive(0, 0, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(bus.d_valid), 64'd0);
        chk("arst_nf", 64'(bus.n_fetched), 64'd0);
        chk("arst_ns", 64'(bus.n_squashed), 64'd0);
        chk("arst_err", 64'(bus.redirect_err), 64'd0);
        chk("arst_stall", 64'(bus.f_stall), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.d_ready = 1'b1;
        repeat (10) drive(1, 0, 0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
